// File: rtl/cap_prop_stimulus_gen_if.sv
// Vector channel between the stimulus generator and a capability property checker.
// Latency: none (wires only).
// Backpressure: out_valid/out_ready handshake on the vector; the checker answers with a chk_valid strobe.
//
// Signals:
//   out_valid   generator offers a vector
//   out_ready   checker accepts the vector
//   out_base    capability base
//   out_len     capability length (base+len never wraps)
//   out_addr    address inside [base, base+len]
//   out_new_len requested length, never above out_len
//   chk_valid   checker verdict strobe
//   chk_ok      verdict, 1 = property held
interface cap_prop_stimulus_gen_if #(
   parameter int ADDR_W = 64
);
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_base;
   logic [ADDR_W-1:0] out_len;
   logic [ADDR_W-1:0] out_addr;
   logic [ADDR_W-1:0] out_new_len;
   logic              chk_valid;
   logic              chk_ok;

   // Generator side.
   modport master (
      output out_valid,
      output out_base,
      output out_len,
      output out_addr,
      output out_new_len,
      input  out_ready,
      input  chk_valid,
      input  chk_ok
   );

   // Checker side.
   modport slave (
      input  out_valid,
      input  out_base,
      input  out_len,
      input  out_addr,
      input  out_new_len,
      output out_ready,
      output chk_valid,
      output chk_ok
   );
endinterface

// File: rtl/cap_prop_stimulus_gen.sv
// Pseudo-random legal capability vector sequencer with pass/fail bookkeeping.
// Latency: start -> first offer in 5 cycles; 6 cycles per vector on the ideal path.
// Backpressure: holds the offered vector stable until out_ready; waits indefinitely for chk_valid.
//
// Ports:
//   CLK, RST_N      clock, synchronous active-low reset
//   start           begin a run (honoured only when idle or done)
//   busy, done      run in progress / run complete
//   vec_if          vector offer channel and checker verdict (master side)
//   pass_count      saturating count of passing vectors this run
//   fail_count      saturating count of failing vectors this run
//   fail_seen       sticky: a failure was seen this run
//   fail_base/len/addr/new_len   first failing vector of this run
module cap_prop_stimulus_gen #(
   parameter int                ADDR_W      = 64,
   parameter logic [ADDR_W-1:0] SEED        = ADDR_W'(1),
   parameter int                NUM_VECTORS = 16,
   parameter int                CNT_W       = 16
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   cap_prop_stimulus_gen_if.master vec_if,
   output logic [CNT_W-1:0]        pass_count,
   output logic [CNT_W-1:0]        fail_count,
   output logic                    fail_seen,
   output logic [ADDR_W-1:0]       fail_base,
   output logic [ADDR_W-1:0]       fail_len,
   output logic [ADDR_W-1:0]       fail_addr,
   output logic [ADDR_W-1:0]       fail_new_len
);

   // Galois feedback mask for x^64+x^63+x^61+x^60+1 (right-shifting form).
   localparam logic [63:0]       POLY64   = 64'hD800_0000_0000_0000;
   localparam logic [ADDR_W-1:0] TAPS     = POLY64[63 -: ADDR_W];
   // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [ADDR_W-1:0] SEED_EFF = (SEED == '0) ? ADDR_W'(1) : SEED;
   localparam int                VC_W     = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
   localparam logic [VC_W-1:0]   VEC_LAST = VC_W'(NUM_VECTORS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_G0    = 3'd1;
   localparam logic [2:0] S_G1    = 3'd2;
   localparam logic [2:0] S_G2    = 3'd3;
   localparam logic [2:0] S_G3    = 3'd4;
   localparam logic [2:0] S_OFFER = 3'd5;
   localparam logic [2:0] S_WAIT  = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   // Masks a random value down to the bit span of len, then folds anything
   // above len back into [0, len]. Since the span mask is < 2*len+2, a single
   // subtraction of (len+1) is enough.
   function automatic logic [ADDR_W-1:0] fold_to_len(input logic [ADDR_W-1:0] raw,
                                                     input logic [ADDR_W-1:0] len);
      logic [ADDR_W-1:0] span;
      logic [ADDR_W-1:0] off;
      span = len;
      for (int i = 1; i < ADDR_W; i++) begin
         span = span | (len >> i);
      end
      off = raw & span;
      if (off > len) begin
         off = off - len - ADDR_W'(1);
      end
      return off;
   endfunction

   logic [2:0]        state_q,        state_d;
   logic [ADDR_W-1:0] lfsr_q,         lfsr_d;
   logic [VC_W-1:0]   vec_cnt_q,      vec_cnt_d;
   logic [ADDR_W-1:0] base_q,         base_d;
   logic [ADDR_W-1:0] len_q,          len_d;
   logic [ADDR_W-1:0] addr_q,         addr_d;
   logic [ADDR_W-1:0] new_len_q,      new_len_d;
   logic [ADDR_W-1:0] out_base_q,     out_base_d;
   logic [ADDR_W-1:0] out_len_q,      out_len_d;
   logic [ADDR_W-1:0] out_addr_q,     out_addr_d;
   logic [ADDR_W-1:0] out_new_len_q,  out_new_len_d;
   logic [CNT_W-1:0]  pass_cnt_q,     pass_cnt_d;
   logic [CNT_W-1:0]  fail_cnt_q,     fail_cnt_d;
   logic              fail_seen_q,    fail_seen_d;
   logic [ADDR_W-1:0] fail_base_q,    fail_base_d;
   logic [ADDR_W-1:0] fail_len_q,     fail_len_d;
   logic [ADDR_W-1:0] fail_addr_q,    fail_addr_d;
   logic [ADDR_W-1:0] fail_new_len_q, fail_new_len_d;

   logic [ADDR_W-1:0] lfsr_next;
   logic [ADDR_W:0]   base_len_sum;
   logic              clear_run;

   assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

   always_comb begin
      state_d        = state_q;
      lfsr_d         = lfsr_q;
      vec_cnt_d      = vec_cnt_q;
      base_d         = base_q;
      len_d          = len_q;
      addr_d         = addr_q;
      new_len_d      = new_len_q;
      out_base_d     = out_base_q;
      out_len_d      = out_len_q;
      out_addr_d     = out_addr_q;
      out_new_len_d  = out_new_len_q;
      pass_cnt_d     = pass_cnt_q;
      fail_cnt_d     = fail_cnt_q;
      fail_seen_d    = fail_seen_q;
      fail_base_d    = fail_base_q;
      fail_len_d     = fail_len_q;
      fail_addr_d    = fail_addr_q;
      fail_new_len_d = fail_new_len_q;
      clear_run      = 1'b0;
      base_len_sum   = {1'b0, base_q} + {1'b0, lfsr_q};

      // The LFSR only moves while a vector is being generated, so the
      // sequence is independent of handshake and verdict timing.
      if (state_q inside {S_G0, S_G1, S_G2, S_G3}) begin
         lfsr_d = lfsr_next;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               clear_run = 1'b1;
               state_d   = S_G0;
            end
         end
         S_G0: begin
            base_d  = lfsr_q;
            state_d = S_G1;
         end
         S_G1: begin
            // A wrapping length is replaced by the largest one that fits,
            // which makes base+len land exactly on the top of the space.
            len_d   = base_len_sum[ADDR_W] ? ~base_q : lfsr_q;
            state_d = S_G2;
         end
         S_G2: begin
            addr_d  = base_q + fold_to_len(lfsr_q, len_q);
            state_d = S_G3;
         end
         S_G3: begin
            new_len_d     = fold_to_len(lfsr_q, len_q);
            // Load the offer registers in one go so they never show a
            // partially built vector.
            out_base_d    = base_q;
            out_len_d     = len_q;
            out_addr_d    = addr_q;
            out_new_len_d = new_len_d;
            state_d       = S_OFFER;
         end
         S_OFFER: begin
            // A verdict strobe here belongs to nothing we offered; drop it.
            if (vec_if.out_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (vec_if.chk_valid) begin
               if (vec_if.chk_ok) begin
                  if (pass_cnt_q != '1) begin
                     pass_cnt_d = pass_cnt_q + CNT_W'(1);
                  end
               end else begin
                  if (fail_cnt_q != '1) begin
                     fail_cnt_d = fail_cnt_q + CNT_W'(1);
                  end
                  if (!fail_seen_q) begin
                     fail_seen_d    = 1'b1;
                     fail_base_d    = out_base_q;
                     fail_len_d     = out_len_q;
                     fail_addr_d    = out_addr_q;
                     fail_new_len_d = out_new_len_q;
                  end
               end
               if (vec_cnt_q == VEC_LAST) begin
                  state_d = S_DONE;
               end else begin
                  vec_cnt_d = vec_cnt_q + VC_W'(1);
                  state_d   = S_G0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (clear_run) begin
         vec_cnt_d      = '0;
         pass_cnt_d     = '0;
         fail_cnt_d     = '0;
         fail_seen_d    = 1'b0;
         fail_base_d    = '0;
         fail_len_d     = '0;
         fail_addr_d    = '0;
         fail_new_len_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q        <= S_IDLE;
         lfsr_q         <= SEED_EFF;
         vec_cnt_q      <= '0;
         base_q         <= '0;
         len_q          <= '0;
         addr_q         <= '0;
         new_len_q      <= '0;
         out_base_q     <= '0;
         out_len_q      <= '0;
         out_addr_q     <= '0;
         out_new_len_q  <= '0;
         pass_cnt_q     <= '0;
         fail_cnt_q     <= '0;
         fail_seen_q    <= 1'b0;
         fail_base_q    <= '0;
         fail_len_q     <= '0;
         fail_addr_q    <= '0;
         fail_new_len_q <= '0;
      end else begin
         state_q        <= state_d;
         lfsr_q         <= lfsr_d;
         vec_cnt_q      <= vec_cnt_d;
         base_q         <= base_d;
         len_q          <= len_d;
         addr_q         <= addr_d;
         new_len_q      <= new_len_d;
         out_base_q     <= out_base_d;
         out_len_q      <= out_len_d;
         out_addr_q     <= out_addr_d;
         out_new_len_q  <= out_new_len_d;
         pass_cnt_q     <= pass_cnt_d;
         fail_cnt_q     <= fail_cnt_d;
         fail_seen_q    <= fail_seen_d;
         fail_base_q    <= fail_base_d;
         fail_len_q     <= fail_len_d;
         fail_addr_q    <= fail_addr_d;
         fail_new_len_q <= fail_new_len_d;
      end
   end

   assign busy               = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done               = (state_q == S_DONE);
   assign vec_if.out_valid   = (state_q == S_OFFER);
   assign vec_if.out_base    = out_base_q;
   assign vec_if.out_len     = out_len_q;
   assign vec_if.out_addr    = out_addr_q;
   assign vec_if.out_new_len = out_new_len_q;
   assign pass_count         = pass_cnt_q;
   assign fail_count         = fail_cnt_q;
   assign fail_seen          = fail_seen_q;
   assign fail_base          = fail_base_q;
   assign fail_len           = fail_len_q;
   assign fail_addr          = fail_addr_q;
   assign fail_new_len       = fail_new_len_q;

endmodule

// File: tb/tb_cap_prop_stimulus_gen.sv
// Bench for cap_prop_stimulus_gen: scoreboarded vectors plus per-scenario checks.
// Latency: n/a.
// Backpressure: the bench plays the checker, stalling out_ready where a scenario calls for it.
module tb_cap_prop_stimulus_gen;
   localparam logic [63:0] SEED1 = 64'hACE1_2468_1357_9BDF;
   localparam logic [63:0] SEED2 = 64'hFFFF_FFFF_FFFF_FFF0;
   localparam logic [63:0] POLY  = 64'hD800_0000_0000_0000;

   typedef struct packed {
      logic [63:0] base;
      logic [63:0] len;
      logic [63:0] addr;
      logic [63:0] nlen;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        start, busy, done, fail_seen;
   logic [15:0] pass_count, fail_count;
   logic [63:0] fail_base, fail_len, fail_addr, fail_new_len;
   logic        start2, busy2, done2, fail_seen2;
   logic [1:0]  pass2, fail2;
   logic [63:0] fail_base2, fail_len2, fail_addr2, fail_new_len2;

   int vectors    = 0;
   int miscompares = 0;
   int cyc        = 0;
   int t0         = 0;

   vec_t        exp_q[$];
   vec_t        exp_log[$];
   vec_t        last_run[$];
   vec_t        run1_vecs[$];
   vec_t        exp2_q[$];
   vec_t        got2_log[$];
   logic [63:0] m_lfsr;
   logic [63:0] m_lfsr2;

   cap_prop_stimulus_gen_if #(.ADDR_W(64)) vif ();
   cap_prop_stimulus_gen_if #(.ADDR_W(64)) vif2 ();

   cap_prop_stimulus_gen #(.ADDR_W(64), .SEED(SEED1), .NUM_VECTORS(4), .CNT_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .busy(busy), .done(done), .vec_if(vif),
      .pass_count(pass_count), .fail_count(fail_count), .fail_seen(fail_seen),
      .fail_base(fail_base), .fail_len(fail_len), .fail_addr(fail_addr), .fail_new_len(fail_new_len)
   );

   cap_prop_stimulus_gen #(.ADDR_W(64), .SEED(SEED2), .NUM_VECTORS(5), .CNT_W(2)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .start(start2), .busy(busy2), .done(done2), .vec_if(vif2),
      .pass_count(pass2), .fail_count(fail2), .fail_seen(fail_seen2),
      .fail_base(fail_base2), .fail_len(fail_len2), .fail_addr(fail_addr2), .fail_new_len(fail_new_len2)
   );

   initial forever #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [63:0] lfsr_step(input logic [63:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   function automatic logic [63:0] limit_to(input logic [63:0] raw, input logic [63:0] len);
      logic [63:0] m, o;
      m = 64'd0;
      for (int i = 0; i < 64; i++) begin
         if (len[i]) m = (i == 63) ? {64{1'b1}} : ((64'd1 << (i + 1)) - 64'd1);
      end
      o = raw & m;
      if (o > len) o = o - len - 64'd1;
      return o;
   endfunction

   task automatic model_vec(inout logic [63:0] s, output vec_t v);
      logic [64:0] sum;
      v.base = s;                    s = lfsr_step(s);
      sum = {1'b0, v.base} + {1'b0, s};
      v.len  = sum[64] ? ~v.base : s; s = lfsr_step(s);
      v.addr = v.base + limit_to(s, v.len); s = lfsr_step(s);
      v.nlen = limit_to(s, v.len);   s = lfsr_step(s);
   endtask

   // ---------------- scoreboards ----------------
   always @(negedge CLK) begin : mon1
      vec_t got, e;
      logic [64:0] s65;
      if (RST_N === 1'b1 && vif.out_valid === 1'b1 && vif.out_ready === 1'b1) begin
         got = {vif.out_base, vif.out_len, vif.out_addr, vif.out_new_len};
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: got base=%h len=%h, no vector expected", got.base, got.len);
         end else begin
            e = exp_q.pop_front();
            exp_log.push_back(e);
            if (got !== e)  begin
               miscompares++;
               $display("FAIL sb_vector: got %h %h %h %h required %h %h %h %h",
                        got.base, got.len, got.addr, got.nlen, e.base, e.len, e.addr, e.nlen);
            end
         end
         s65 = {1'b0, got.base} + {1'b0, got.len};
         vectors++;
         if (s65[64] !== 1'b0) begin
            miscompares++;
            $display("FAIL prop_no_carry: base=%h len=%h wraps", got.base, got.len);
         end
         vectors++;
         if (!(got.addr >= got.base && (got.addr - got.base) <= got.len)) begin
            miscompares++;
            $display("FAIL prop_addr_in_bounds: addr=%h base=%h len=%h", got.addr, got.base, got.len);
         end
         vectors++;
         if (got.nlen > got.len) begin
            miscompares++;
            $display("FAIL prop_new_len: new_len=%h above len=%h", got.nlen, got.len);
         end
      end
   end

   always @(negedge CLK) begin : mon2
      vec_t got, e;
      if (RST_N === 1'b1 && vif2.out_valid === 1'b1 && vif2.out_ready === 1'b1) begin
         got = {vif2.out_base, vif2.out_len, vif2.out_addr, vif2.out_new_len};
         got2_log.push_back(got);
         vectors++;
         if (exp2_q.size() == 0) begin
            miscompares++;
            $display("FAIL sb2_unexpected: got base=%h", got.base);
         end else begin
            e = exp2_q.pop_front();
            if (got !== e) begin
               miscompares++;
               $display("FAIL sb2_vector: got %h %h %h %h required %h %h %h %h",
                        got.base, got.len, got.addr, got.nlen, e.base, e.len, e.addr, e.nlen);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_run();
      vec_t v;
      last_run.delete();
      exp_log.delete();
      for (int i = 0; i < 4; i++) begin
         model_vec(m_lfsr, v);
         exp_q.push_back(v);
         last_run.push_back(v);
      end
      t0 = cyc;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   // Plays the checker: accept each vector, answer one cycle after the handshake.
   task automatic serve(input int n, input logic [31:0] fail_mask);
      for (int i = 0; i < n; i++) begin
         int   guard;
         logic hs;
         vif.out_ready = 1'b1;
         guard = 0;
         hs    = 1'b0;
         while (!hs && guard < 200) begin
            hs = (vif.out_valid === 1'b1);
            @(posedge CLK); #1;
            guard++;
         end
         vif.out_ready = 1'b0;
         if (!hs) begin
            vectors++; miscompares++;
            $display("FAIL serve_timeout: vector %0d never offered", i);
            return;
         end
         vif.chk_valid = 1'b1;
         vif.chk_ok    = ~fail_mask[i];
         @(posedge CLK); #1;
         vif.chk_valid = 1'b0;
         vif.chk_ok    = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      vectors++;
      if ({busy, done, vif.out_valid, fail_seen, pass_count, fail_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_status: busy=%b done=%b valid=%b seen=%b pass=%0d fail=%0d required all 0",
                  busy, done, vif.out_valid, fail_seen, pass_count, fail_count);
      end
      vectors++;
      if ({vif.out_base, vif.out_len, vif.out_addr, vif.out_new_len} !== '0) begin
         miscompares++;
         $display("FAIL reset_out_vec: base=%h len=%h required 0", vif.out_base, vif.out_len);
      end
      vectors++;
      if ({fail_base, fail_len, fail_addr, fail_new_len} !== '0) begin
         miscompares++;
         $display("FAIL reset_fail_vec: fail_base=%h required 0", fail_base);
      end
      RST_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold: busy=%b done=%b required 0 0", busy, done);
      end
   endtask

   task automatic test_basic_run();
      start_run();
      run1_vecs = last_run;
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_busy: busy=%b done=%b required 1 0", busy, done);
      end
      serve(4, 32'h0);
      vectors++;
      if (done !== 1'b1 || (cyc - t0) !== 25) begin
         miscompares++;
         $display("FAIL basic_done_time: done=%b at +%0d required 1 at +25", done, cyc - t0);
      end
      vectors++;
      if (pass_count !== 16'd4 || fail_count !== 16'd0 || fail_seen !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_counts: pass=%0d fail=%0d seen=%b required 4 0 0", pass_count, fail_count, fail_seen);
      end
   endtask

   task automatic test_ready_stall();
      int guard;
      vec_t e;
      start_run();
      e = last_run[0];
      guard = 0;
      while (vif.out_valid !== 1'b1 && guard < 50) begin
         @(posedge CLK); #1;
         guard++;
      end
      for (int k = 0; k < 10; k++) begin
         vectors++;
         if (vif.out_valid !== 1'b1 ||
             {vif.out_base, vif.out_len, vif.out_addr, vif.out_new_len} !== e) begin
            miscompares++;
            $display("FAIL stall_hold: cycle %0d valid=%b base=%h required 1 %h", k, vif.out_valid, vif.out_base, e.base);
         end
         @(posedge CLK); #1;
      end
      serve(4, 32'h0);
      vectors++;
      if (done !== 1'b1 || pass_count !== 16'd4) begin
         miscompares++;
         $display("FAIL stall_resume: done=%b pass=%0d required 1 4", done, pass_count);
      end
   endtask

   task automatic test_fail_capture();
      start_run();
      serve(4, 32'b0110);
      vectors++;
      if (fail_count !== 16'd2 || pass_count !== 16'd2 || fail_seen !== 1'b1) begin
         miscompares++;
         $display("FAIL failcap_counts: pass=%0d fail=%0d seen=%b required 2 2 1", pass_count, fail_count, fail_seen);
      end
      vectors++;
      if (exp_log.size() < 2) begin
         miscompares++;
         $display("FAIL failcap_log: %0d vectors accepted, required 4", exp_log.size());
      end else if ({fail_base, fail_len, fail_addr, fail_new_len} !== exp_log[1]) begin
         miscompares++;
         $display("FAIL failcap_vector: got %h %h %h %h required %h %h %h %h", fail_base, fail_len, fail_addr,
                  fail_new_len, exp_log[1].base, exp_log[1].len, exp_log[1].addr, exp_log[1].nlen);
      end
   endtask

   task automatic test_ignore_and_restart();
      vectors++;
      if (done !== 1'b1 || fail_count !== 16'd2) begin
         miscompares++;
         $display("FAIL restart_pre: done=%b fail=%0d required 1 2", done, fail_count);
      end
      start_run();
      vectors++;
      if ({pass_count, fail_count, fail_seen} !== '0 || {fail_base, fail_len, fail_addr, fail_new_len} !== '0
          || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_clear: pass=%0d fail=%0d seen=%b fbase=%h busy=%b required 0 0 0 0 1",
                  pass_count, fail_count, fail_seen, fail_base, busy);
      end
      repeat (2) begin @(posedge CLK); #1; end
      start = 1'b1;                       // now in G2
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      vectors++;
      if (vif.out_valid !== 1'b1 || (cyc - t0) !== 5) begin
         miscompares++;
         $display("FAIL ignore_start: valid=%b at +%0d required 1 at +5", vif.out_valid, cyc - t0);
      end
      vif.chk_valid = 1'b1; vif.chk_ok = 1'b0;   // stray verdict while offering
      @(posedge CLK); #1;
      vif.out_ready = 1'b1;                      // stray verdict on the handshake cycle
      @(posedge CLK); #1;
      vif.out_ready = 1'b0;
      vectors++;
      if (vif.out_valid !== 1'b0 || fail_count !== 16'd0 || pass_count !== 16'd0) begin
         miscompares++;
         $display("FAIL ignore_chk: valid=%b fail=%0d pass=%0d required 0 0 0", vif.out_valid, fail_count, pass_count);
      end
      vif.chk_ok = 1'b1;
      @(posedge CLK); #1;
      vif.chk_valid = 1'b0; vif.chk_ok = 1'b0;
      serve(3, 32'h0);
      vectors++;
      if (done !== 1'b1 || pass_count !== 16'd4 || fail_count !== 16'd0 || (cyc - t0) !== 26) begin
         miscompares++;
         $display("FAIL ignore_final: done=%b pass=%0d fail=%0d at +%0d required 1 4 0 at +26",
                  done, pass_count, fail_count, cyc - t0);
      end
   endtask

   task automatic test_properties();
      for (int r = 0; r < 200; r++) begin
         logic [31:0] mask;
         mask = 32'($urandom_range(0, 15));
         start_run();
         serve(4, mask);
         vectors++;
         if (done !== 1'b1 || fail_count !== 16'($countones(mask)) || pass_count !== 16'(4 - $countones(mask))) begin
            miscompares++;
            $display("FAIL props_run %0d: done=%b pass=%0d fail=%0d mask=%b", r, done, pass_count, fail_count, mask[3:0]);
         end
      end
   endtask

   task automatic test_midrun_reset();
      int   guard;
      logic hs;
      vec_t v;
      start_run();
      serve(1, 32'h0);
      vif.out_ready = 1'b1;
      guard = 0; hs = 1'b0;
      while (!hs && guard < 50) begin
         hs = (vif.out_valid === 1'b1);
         @(posedge CLK); #1;
         guard++;
      end
      vif.out_ready = 1'b0;
      vectors++;
      if (!hs || pass_count !== 16'd1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL midreset_pre: hs=%b pass=%0d busy=%b required 1 1 1", hs, pass_count, busy);
      end
      RST_N = 1'b0;
      @(posedge CLK); #1;
      vectors++;
      if ({busy, done, vif.out_valid, fail_seen, pass_count, fail_count} !== '0 ||
          {vif.out_base, vif.out_len, vif.out_addr, vif.out_new_len} !== '0) begin
         miscompares++;
         $display("FAIL midreset_state: busy=%b pass=%0d base=%h required 0 0 0", busy, pass_count, vif.out_base);
      end
      RST_N = 1'b1;
      exp_q.delete();
      exp_log.delete();
      m_lfsr = SEED1;
      for (int i = 0; i < 4; i++) model_vec(m_lfsr, v);
      for (int i = 0; i < run1_vecs.size(); i++) exp_q.push_back(run1_vecs[i]);
      @(posedge CLK); #1;
      t0 = cyc;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      serve(4, 32'h0);
      vectors++;
      if (done !== 1'b1 || pass_count !== 16'd4 || (cyc - t0) !== 25 || exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL midreset_replay: done=%b pass=%0d at +%0d left=%0d required 1 4 +25 0",
                  done, pass_count, cyc - t0, exp_q.size());
      end
   endtask

   task automatic test_boundary_seed();
      vec_t v;
      m_lfsr2 = SEED2;
      for (int i = 0; i < 5; i++) begin
         model_vec(m_lfsr2, v);
         exp2_q.push_back(v);
      end
      start2 = 1'b1;
      @(posedge CLK); #1;
      start2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         int   guard;
         logic hs;
         vif2.out_ready = 1'b1;
         guard = 0; hs = 1'b0;
         while (!hs && guard < 200) begin
            hs = (vif2.out_valid === 1'b1);
            @(posedge CLK); #1;
            guard++;
         end
         vif2.out_ready = 1'b0;
         vif2.chk_valid = 1'b1; vif2.chk_ok = 1'b1;
         @(posedge CLK); #1;
         vif2.chk_valid = 1'b0; vif2.chk_ok = 1'b0;
      end
      vectors++;
      if (got2_log.size() !== 5) begin
         miscompares++;
         $display("FAIL edge_count: %0d vectors accepted, required 5", got2_log.size());
      end else begin
         vectors++;
         if (got2_log[0].base !== SEED2 || got2_log[0].len > 64'd15) begin
            miscompares++;
            $display("FAIL edge_top_base: base=%h len=%h required base %h len<=15", got2_log[0].base, got2_log[0].len, SEED2);
         end
      end
      vectors++;
      if (done2 !== 1'b1 || pass2 !== 2'd3 || fail2 !== 2'd0) begin
         miscompares++;
         $display("FAIL edge_saturate: done=%b pass=%0d fail=%0d required 1 3 0", done2, pass2, fail2);
      end
   endtask

   initial begin
      RST_N = 1'b0;
      start = 1'b0;  start2 = 1'b0;
      vif.out_ready  = 1'b0; vif.chk_valid  = 1'b0; vif.chk_ok  = 1'b0;
      vif2.out_ready = 1'b0; vif2.chk_valid = 1'b0; vif2.chk_ok = 1'b0;
      m_lfsr  = SEED1;
      m_lfsr2 = SEED2;
      test_reset();
      test_basic_run();
      test_ready_stall();
      test_fail_capture();
      test_ignore_and_restart();
      test_properties();
      test_midrun_reset();
      test_boundary_seed();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
